// File: rtl/sid_writer.sv
// sid_writer: SID register-port initiator; FIFO-queued timed writes/reads paced by clkEn, in-order read responses.
module sid_writer #(
    parameter int DEPTH = 16,
    parameter int DW    = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clkEn,
    input  logic                   iCmdValid,
    output logic                   oCmdReady,
    input  logic [DW+13:0]         iCmd,
    output logic                   oWE,
    output logic [4:0]             oAddr,
    output logic [7:0]             oDataW,
    input  logic [7:0]             iDataR,
    output logic                   oRspValid,
    input  logic                   iRspReady,
    output logic [12:0]            oRsp,
    output logic                   oBusy,
    output logic [$clog2(DEPTH):0] oLevel
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = DW + 14;

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;

    logic [CW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q, level_d;
    state_t        state_q;
    logic          rd_q;
    logic [DW-1:0] cnt_q;
    logic [4:0]    addr_q;
    logic [7:0]    data_q;
    logic          we_q, rsp_valid_q;
    logic [4:0]    oaddr_q;
    logic [7:0]    odata_q;
    logic [12:0]   rsp_q;
    logic          push, pop;

    assign oCmdReady = level_q != (AW+1)'(DEPTH);
    assign push      = iCmdValid && oCmdReady;
    assign pop       = (state_q == IDLE) && (level_q != '0);
    assign level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= iCmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Only clkEn pulses seen in WAIT count, so delay 0 still costs one fresh tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            oaddr_q     <= '0;
            odata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    {rd_q, cnt_q, addr_q, data_q} <= mem_q[rptr_q];
                    state_q <= WAIT;
                end
                WAIT: if (clkEn) begin
                    if (cnt_q == '0) begin
                        state_q <= ISSUE;
                        oaddr_q <= addr_q;
                        we_q    <= !rd_q;
                        if (!rd_q) odata_q <= data_q;
                    end else begin
                        cnt_q <= cnt_q - DW'(1);
                    end
                end
                ISSUE: begin
                    state_q <= rd_q ? RESP : IDLE;
                    if (rd_q) begin
                        rsp_q       <= {oaddr_q, iDataR};
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: if (iRspReady) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oWE       = we_q;
    assign oAddr     = oaddr_q;
    assign oDataW    = odata_q;
    assign oRspValid = rsp_valid_q;
    assign oRsp      = rsp_q;
    assign oLevel    = level_q;
    assign oBusy     = (state_q != IDLE) || (level_q != '0);
endmodule

// File: tb/tb_sid_writer.sv
// tb_sid_writer: table-driven and randomized checks of sid_writer against a transaction-level reference model.
module tb_sid_writer;
    localparam int DEPTH = 16;
    localparam int DW    = 10;
    localparam int CW    = DW + 14;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clkEn = 1'b0;
    logic                   iCmdValid = 1'b0;
    logic                   oCmdReady;
    logic [CW-1:0]          iCmd = '0;
    logic                   oWE;
    logic [4:0]             oAddr;
    logic [7:0]             oDataW;
    logic [7:0]             iDataR;
    logic                   oRspValid;
    logic                   iRspReady = 1'b0;
    logic [12:0]            oRsp;
    logic                   oBusy;
    logic [$clog2(DEPTH):0] oLevel;

    sid_writer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clkEn(clkEn), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iCmd(iCmd), .oWE(oWE), .oAddr(oAddr), .oDataW(oDataW), .iDataR(iDataR),
        .oRspValid(oRspValid), .iRspReady(iRspReady), .oRsp(oRsp), .oBusy(oBusy), .oLevel(oLevel)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fdat(input logic [4:0] a);
        return (a == 5'h1B) ? 8'hA5 : 8'({3'b000, a} * 8'd7 + 8'd3);
    endfunction

    assign iDataR = fdat(oAddr);

    function automatic logic [CW-1:0] mk(input bit rd, input int dly, input int addr, input int data);
        return {rd, DW'(dly), 5'(addr), 8'(data)};
    endfunction

    int vec = 0, errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    int cyc = 0, ce_cnt = 0, we_cnt = 0, ce_mode = 0, ce_per = 16;
    logic [4:0] we_log[$];
    int         we_ce[$];

    // Reference model: a queue of commands plus "clkEn pulses still owed" for the loaded one.
    logic [CW-1:0] q[$];
    logic [CW-1:0] m_cur = '0;
    bit            m_ld = 0, m_iss = 0, m_rsp = 0, m_push = 0;
    int            m_need = 0;
    logic [4:0]    m_addr = '0;
    logic [7:0]    m_data = '0;
    logic [12:0]   m_rspv = '0;

    always @(negedge clk) begin
        cyc++;
        if (clkEn) ce_cnt++;
        if (!rst_n) begin
            q.delete();
            m_ld = 0; m_iss = 0; m_rsp = 0;
            m_addr = '0; m_data = '0; m_rspv = '0;
        end else begin
            m_push = iCmdValid && (q.size() != DEPTH);
            if (m_rsp) begin
                m_rsp = !iRspReady;
            end else if (m_iss) begin
                m_iss = 0;
                if (m_cur[CW-1]) begin
                    m_rsp  = 1;
                    m_rspv = {m_addr, fdat(m_addr)};
                end
            end else if (m_ld) begin
                if (clkEn) m_need--;
                if (m_need == 0) begin
                    m_ld   = 0;
                    m_iss  = 1;
                    m_addr = m_cur[12:8];
                    if (!m_cur[CW-1]) m_data = m_cur[7:0];
                end
            end else if (q.size() != 0) begin
                m_cur  = q.pop_front();
                m_ld   = 1;
                m_need = int'(m_cur[CW-2:13]) + 1;
            end
            if (m_push) q.push_back(iCmd);
        end
        chk("m_oWE", oWE, m_iss && !m_cur[CW-1]);
        chk("m_oAddr", oAddr, m_addr);
        chk("m_oDataW", oDataW, m_data);
        chk("m_oRspValid", oRspValid, m_rsp);
        if (m_rsp) chk("m_oRsp", oRsp, m_rspv);
        chk("m_oLevel", oLevel, q.size());
        chk("m_oCmdReady", oCmdReady, q.size() != DEPTH);
        chk("m_oBusy", oBusy, m_ld || m_iss || m_rsp || q.size() != 0);
        if (oWE) begin
            we_cnt++;
            we_log.push_back(oAddr);
            we_ce.push_back(ce_cnt);
        end
        clkEn = (ce_mode == 2) ? ($urandom_range(0, 3) == 0) : (ce_mode == 1 && cyc % ce_per == 0);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [CW-1:0] c);
        iCmdValid = 1'b1;
        iCmd      = c;
        for (int i = 0; i < 2000 && !oCmdReady; i++) step(1);
        step(1);
        iCmdValid = 1'b0;
    endtask

    task automatic wait_for(input int what, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            step(1);
            ok = (what == 0) ? oWE : (what == 1) ? oRspValid : !oBusy;
        end
    endtask

    typedef struct {
        bit rd;
        int dly;
        int addr;
        int data;
        int ticks;
        int rsp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit ok, rdy, stable;
        int base, acc;
        tbl[0] = '{1'b0, 0,    'h18, 'h1F, 1,    0};
        tbl[1] = '{1'b0, 3,    'h00, 'h11, 4,    0};
        tbl[2] = '{1'b1, 0,    'h1B, 'h00, 1,    'h1BA5};
        tbl[3] = '{1'b1, 2,    'h05, 'h00, 3,    'h0526};
        tbl[4] = '{1'b0, 7,    'h1F, 'hFF, 8,    0};
        tbl[5] = '{1'b1, 1,    'h00, 'h00, 2,    'h0003};
        tbl[6] = '{1'b0, 1023, 'h0A, 'h5A, 1024, 0};

        step(3);
        chk("rst_ready", oCmdReady, 1);
        chk("rst_we", oWE, 0);
        chk("rst_level", oLevel, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_rspvalid", oRspValid, 0);
        chk("rst_rsp", oRsp, 0);
        chk("rst_addr", oAddr, 0);
        chk("rst_dataw", oDataW, 0);
        rst_n = 1'b1;
        step(2);

        ce_mode = 1;
        ce_per  = 16;
        for (int i = 0; i < 7; i++) begin
            push(mk(tbl[i].rd, tbl[i].dly, tbl[i].addr, tbl[i].data));
            step(1);
            base = ce_cnt;
            wait_for(tbl[i].rd ? 1 : 0, (tbl[i].dly + 2) * 16 + 40, ok);
            chk("tbl_done", ok, 1);
            chk("tbl_ticks", ce_cnt - base, tbl[i].ticks);
            if (!tbl[i].rd) begin
                chk("tbl_addr", oAddr, tbl[i].addr);
                chk("tbl_dataw", oDataW, tbl[i].data);
                step(1);
                chk("tbl_we_once", oWE, 0);
            end else begin
                chk("tbl_rsp", oRsp, tbl[i].rsp);
                iRspReady = 1'b1;
                step(1);
                iRspReady = 1'b0;
            end
            step(2);
            chk("tbl_idle", oBusy, 0);
        end

        we_log.delete();
        we_ce.delete();
        push(mk(0, 3, 'h00, 'h11));
        push(mk(0, 0, 'h01, 'h22));
        base = ce_cnt;
        for (int i = 0; i < 300 && we_log.size() < 2; i++) step(1);
        chk("b2b_count", we_log.size(), 2);
        if (we_log.size() == 2) begin
            chk("b2b_first_ticks", we_ce[0] - base, 4);
            chk("b2b_gap_ticks", we_ce[1] - we_ce[0], 1);
            chk("b2b_addr0", we_log[0], 'h00);
            chk("b2b_addr1", we_log[1], 'h01);
        end
        wait_for(2, 200, ok);
        chk("b2b_idle", ok, 1);

        push(mk(1, 0, 'h1B, 0));
        push(mk(0, 0, 'h02, 'h33));
        wait_for(1, 100, ok);
        chk("rsp_seen", ok, 1);
        stable = 1;
        for (int i = 0; i < 50; i++) begin
            stable = stable && oRspValid && (oRsp == 13'h1BA5) && !oWE;
            step(1);
        end
        chk("rsp_hold", stable, 1);
        chk("rsp_queued", oLevel, 1);
        iRspReady = 1'b1;
        step(1);
        iRspReady = 1'b0;
        wait_for(0, 100, ok);
        chk("rsp_then_write", ok, 1);
        chk("rsp_write_addr", oAddr, 'h02);
        chk("rsp_write_data", oDataW, 'h33);
        wait_for(2, 100, ok);

        ce_mode = 0;
        we_log.delete();
        acc = 0;
        for (int i = 0; i < 40 && acc < 19; i++) begin
            iCmdValid = 1'b1;
            iCmd = mk(0, 0, acc, acc + 'h40);
            rdy = oCmdReady;
            step(1);
            if (rdy) acc++;
        end
        chk("full_accepted", acc, DEPTH + 1);
        chk("full_level", oLevel, DEPTH);
        chk("full_ready", oCmdReady, 0);
        ce_mode = 1;
        ce_per  = 2;
        for (int i = 0; i < 500 && acc < 19; i++) begin
            iCmdValid = 1'b1;
            iCmd = mk(0, 0, acc, acc + 'h40);
            rdy = oCmdReady;
            step(1);
            if (rdy) acc++;
        end
        iCmdValid = 1'b0;
        chk("fill_all", acc, 19);
        wait_for(2, 2000, ok);
        chk("drain_done", ok, 1);
        chk("drain_count", we_log.size(), 19);
        for (int i = 0; i < we_log.size() && i < 19; i++) chk("drain_order", we_log[i], i);

        ce_mode = 0;
        for (int i = 0; i < 6; i++) push(mk(0, 0, 'h10 + i, i));
        step(2);
        chk("rst_pre_level", oLevel, 5);
        ce_mode = 1;
        ce_per  = 8;
        wait_for(0, 100, ok);
        chk("rst_issue_seen", ok, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_we_drop", oWE, 0);
        chk("rst_level_drop", oLevel, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("rst_post_level", oLevel, 0);
        chk("rst_post_ready", oCmdReady, 1);
        base = we_cnt;
        step(100);
        chk("rst_no_we", we_cnt - base, 0);

        ce_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            iCmdValid = ($urandom_range(0, 2) == 0);
            iCmd = mk($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 255));
            iRspReady = ($urandom_range(0, 1) == 1);
            step(1);
        end
        iCmdValid = 1'b0;
        iRspReady = 1'b1;
        wait_for(2, 3000, ok);
        chk("rand_drain", ok, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
